// File: rtl/multdiv_ctrl.sv
// Sequencing FSM for the multi-cycle multiplier/divider: latches operands on a
// start pulse, steps the datapath while counter16 runs, then pulses ready.
module multdiv_ctrl #(
  parameter int WIDTH = 32,
  parameter int ITERS = 16
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic [3:0]       cnt,
  output logic             cnt_clr,
  output logic [WIDTH-1:0] op_a,
  output logic [WIDTH-1:0] op_b,
  output logic             is_div,
  output logic             load,
  output logic             step,
  output logic             busy,
  output logic             data_resultRDY,
  output logic             data_exception
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_DONE
  } state_e;

  // Count value seen on the final datapath step.
  localparam logic [3:0] LAST_CNT = 4'(ITERS - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] op_a_q, op_a_d;
  logic [WIDTH-1:0] op_b_q, op_b_d;
  logic             is_div_q, is_div_d;
  logic             flag_q, flag_d;
  logic             cnt_clr_q, cnt_clr_d;
  logic             load_q, load_d;
  logic             step_q, step_d;
  logic             busy_q, busy_d;
  logic             rdy_q, rdy_d;
  logic             exc_q, exc_d;
  logic             start;

  assign start = ctrl_MULT | ctrl_DIV;

  always_comb begin
    // NOTE: every variable gets a default first, so no path leaves it unassigned
    // and no latch is inferred.
    state_d  = state_q;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    is_div_d = is_div_q;
    flag_d   = flag_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_a_d   = data_operandA;
          op_b_d   = data_operandB;
          is_div_d = ctrl_DIV & ~ctrl_MULT;
          state_d  = S_LOAD;
        end
      end
      S_LOAD: begin
        if (is_div_q && (op_b_q == '0)) begin
          flag_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (cnt == LAST_CNT) state_d = S_DONE;
      end
      S_DONE: begin
        flag_d = 1'b0;
        if (start) begin
          op_a_d   = data_operandA;
          op_b_d   = data_operandB;
          is_div_d = ctrl_DIV & ~ctrl_MULT;
          state_d  = S_LOAD;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered alongside the state they decode, so each one
    // lines up with state_q in the following cycle.
    load_d    = (state_d == S_LOAD);
    step_d    = (state_d == S_RUN);
    busy_d    = (state_d == S_LOAD) || (state_d == S_RUN);
    rdy_d     = (state_d == S_DONE);
    exc_d     = (state_d == S_DONE) && flag_d;
    cnt_clr_d = (state_d != S_RUN);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of its neighbours.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q   <= S_IDLE;
      op_a_q    <= '0;
      op_b_q    <= '0;
      is_div_q  <= 1'b0;
      flag_q    <= 1'b0;
      cnt_clr_q <= 1'b1;
      load_q    <= 1'b0;
      step_q    <= 1'b0;
      busy_q    <= 1'b0;
      rdy_q     <= 1'b0;
      exc_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_a_q    <= op_a_d;
      op_b_q    <= op_b_d;
      is_div_q  <= is_div_d;
      flag_q    <= flag_d;
      cnt_clr_q <= cnt_clr_d;
      load_q    <= load_d;
      step_q    <= step_d;
      busy_q    <= busy_d;
      rdy_q     <= rdy_d;
      exc_q     <= exc_d;
    end
  end

  assign cnt_clr        = cnt_clr_q;
  assign op_a           = op_a_q;
  assign op_b           = op_b_q;
  assign is_div         = is_div_q;
  assign load           = load_q;
  assign step           = step_q;
  assign busy           = busy_q;
  assign data_resultRDY = rdy_q;
  assign data_exception = exc_q;

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Scoreboard bench for multdiv_ctrl with a behavioural counter16 attached;
// expected completions are queued at start time and retired by a monitor.
module tb_multdiv_ctrl;
  localparam int WIDTH = 32;
  localparam int ITERS = 16;

  logic             clk = 1'b0;
  logic             clr_n = 1'b0;
  logic             ctrl_MULT = 1'b0;
  logic             ctrl_DIV = 1'b0;
  logic [WIDTH-1:0] data_operandA = '0;
  logic [WIDTH-1:0] data_operandB = '0;
  logic [3:0]       cnt = 4'd0;
  logic             cnt_clr;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             is_div;
  logic             load;
  logic             step;
  logic             busy;
  logic             data_resultRDY;
  logic             data_exception;

  multdiv_ctrl #(.WIDTH(WIDTH), .ITERS(ITERS)) dut (
    .clk            (clk),
    .clr_n          (clr_n),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .cnt            (cnt),
    .cnt_clr        (cnt_clr),
    .op_a           (op_a),
    .op_b           (op_b),
    .is_div         (is_div),
    .load           (load),
    .step           (step),
    .busy           (busy),
    .data_resultRDY (data_resultRDY),
    .data_exception (data_exception)
  );

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    bit               div;
    bit               exc;
    int               rdy_cyc;
    int               steps;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_pass = 0;
  int   cyc = 0;
  int   steps_seen = 0;
  int   loads_seen = 0;
  int   busy_seen = 0;
  int   rdy_total = 0;
  int   inv_bad = 0;
  logic prev_load = 1'b0;

  localparam logic [70:0] RESET_VEC = {1'b1, 6'b0, 64'b0};

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // counter16: synchronous clear, otherwise counts up every cycle
  always @(posedge clk) cnt <= cnt_clr ? 4'd0 : cnt + 4'd1;

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [70:0] out_vec();
    return {cnt_clr, load, step, busy, data_resultRDY, data_exception, is_div, op_a, op_b};
  endfunction

  // Monitor: samples on the falling edge, retires one expectation per ready pulse.
  always @(negedge clk) begin
    if (step && prev_load) check("cnt_zero_first_run", 128'(cnt), 128'(0));
    prev_load = load;
    if (step) steps_seen++;
    if (load) loads_seen++;
    if (busy) busy_seen++;
    if (data_exception && !data_resultRDY) inv_bad++;
    if (cnt_clr == step) inv_bad++;
    if (busy && exp_q.size() > 0 &&
        (op_a !== exp_q[0].a || op_b !== exp_q[0].b || is_div !== exp_q[0].div)) inv_bad++;
    if (data_resultRDY) begin
      rdy_total++;
      if (exp_q.size() == 0) begin
        check("unexpected_ready", 128'(1), 128'(0));
      end else begin
        mon_e = exp_q.pop_front();
        check("ready_latency", 128'(cyc), 128'(mon_e.rdy_cyc));
        check("exception", 128'(data_exception), 128'(mon_e.exc));
        check("is_div", 128'(is_div), 128'(mon_e.div));
        check("op_a", 128'(op_a), 128'(mon_e.a));
        check("op_b", 128'(op_b), 128'(mon_e.b));
        check("step_cycles", 128'(steps_seen), 128'(mon_e.steps));
        check("load_cycles", 128'(loads_seen), 128'(1));
        check("busy_cycles", 128'(busy_seen), 128'(1 + mon_e.steps));
        check("busy_low_at_ready", 128'(busy), 128'(0));
      end
      steps_seen = 0;
      loads_seen = 0;
      busy_seen  = 0;
    end
  end

  // Issues one operation at the current falling edge and returns at the falling
  // edge of its predicted ready cycle (or after an abort if abort_at != 0).
  task automatic do_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input bit m, input bit d, input bit noise, input int abort_at);
    exp_t e;
    int   c;
    int   lat;
    int   nc;
    int   r0;
    bit   done;
    c = cyc;
    ctrl_MULT = m;
    ctrl_DIV = d;
    data_operandA = a;
    data_operandB = b;
    e.a = a;
    e.b = b;
    e.div = d && !m;
    e.exc = e.div && (b == '0);
    e.steps = e.exc ? 0 : ITERS;
    lat = e.exc ? 2 : ITERS + 2;
    e.rdy_cyc = c + lat;
    exp_q.push_back(e);
    nc = c + 1 + $urandom_range(0, lat - 2);
    done = 1'b0;
    while (!done) begin
      @(negedge clk);
      ctrl_MULT = 1'b0;
      ctrl_DIV = 1'b0;
      if (cyc == c + lat) begin
        done = 1'b1;
      end else if (abort_at != 0 && cyc == c + abort_at) begin
        #2 clr_n = 1'b0;
        #1 check("abort_outputs", 128'(out_vec()), 128'(RESET_VEC));
        exp_q.delete();
        steps_seen = 0;
        loads_seen = 0;
        busy_seen = 0;
        @(negedge clk);
        clr_n = 1'b1;
        r0 = rdy_total;
        repeat (ITERS + 4) @(negedge clk);
        check("no_ready_after_abort", 128'(rdy_total - r0), 128'(0));
        return;
      end else if (noise && cyc == nc) begin
        ctrl_MULT = 1'($urandom_range(0, 1));
        ctrl_DIV = !ctrl_MULT;
        data_operandA = $urandom;
        data_operandB = $urandom;
      end
    end
  endtask

  initial begin
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    int               sel;
    repeat (2) @(negedge clk);
    check("reset_state", 128'(out_vec()), 128'(RESET_VEC));
    clr_n = 1'b1;
    @(negedge clk);

    do_op(32'd7, 32'd6, 1'b1, 1'b0, 1'b0, 0);          // plain multiply
    repeat (2) @(negedge clk);
    do_op(32'd100, 32'd0, 1'b0, 1'b1, 1'b0, 0);        // divide by zero
    @(negedge clk);
    do_op(32'd11, 32'd0, 1'b1, 1'b1, 1'b0, 0);         // both starts: multiply wins
    @(negedge clk);
    do_op(32'hDEAD_BEEF, 32'h1234, 1'b1, 1'b0, 1'b1, 0); // start pulse during RUN
    @(negedge clk);
    do_op(32'd50, 32'd9, 1'b0, 1'b1, 1'b0, 0);
    do_op(32'd81, 32'd3, 1'b0, 1'b1, 1'b0, 0);         // back-to-back from DONE
    @(negedge clk);
    do_op(32'd5, 32'd5, 1'b1, 1'b0, 1'b0, 6);          // reset mid-RUN

    for (int i = 0; i < 30; i++) begin
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? '0 : $urandom;
      sel = $urandom_range(0, 2);
      do_op(ra, rb, sel != 1, sel != 0, 1'($urandom_range(0, 1)), 0);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    @(negedge clk);
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
    check("queue_drained", 128'(exp_q.size()), 128'(0));
    check("invariants", 128'(inv_bad), 128'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
